// File: rtl/lfsr_burst_sequencer_pkg.sv
// lfsr_burst_sequencer_pkg: sequencer state encoding and XNOR LFSR tap table.
package lfsr_burst_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    function automatic logic [31:0] tap(input int p);
        return 32'd1 << (p - 1);
    endfunction

    // Maximal-length XNOR taps (1-indexed bit positions), two or four per width.
    function automatic logic [31:0] tap_mask(input int n);
        case (n)
            3:       return tap(3)  | tap(2);
            4:       return tap(4)  | tap(3);
            5:       return tap(5)  | tap(3);
            6:       return tap(6)  | tap(5);
            7:       return tap(7)  | tap(6);
            8:       return tap(8)  | tap(6)  | tap(5) | tap(4);
            9:       return tap(9)  | tap(5);
            10:      return tap(10) | tap(7);
            11:      return tap(11) | tap(9);
            12:      return tap(12) | tap(6)  | tap(4) | tap(1);
            13:      return tap(13) | tap(4)  | tap(3) | tap(1);
            14:      return tap(14) | tap(5)  | tap(3) | tap(1);
            15:      return tap(15) | tap(14);
            16:      return tap(16) | tap(15) | tap(13) | tap(4);
            17:      return tap(17) | tap(14);
            18:      return tap(18) | tap(11);
            19:      return tap(19) | tap(6)  | tap(2) | tap(1);
            20:      return tap(20) | tap(17);
            21:      return tap(21) | tap(19);
            22:      return tap(22) | tap(21);
            23:      return tap(23) | tap(18);
            24:      return tap(24) | tap(23) | tap(22) | tap(17);
            25:      return tap(25) | tap(22);
            26:      return tap(26) | tap(6)  | tap(2) | tap(1);
            27:      return tap(27) | tap(5)  | tap(2) | tap(1);
            28:      return tap(28) | tap(25);
            29:      return tap(29) | tap(27);
            30:      return tap(30) | tap(6)  | tap(4) | tap(1);
            31:      return tap(31) | tap(28);
            default: return tap(32) | tap(22) | tap(2) | tap(1);
        endcase
    endfunction

endpackage

// File: rtl/lfsr_burst_sequencer_lfsr.sv
// lfsr_burst_sequencer_lfsr: loadable XNOR Fibonacci LFSR; contents are never reset.
module lfsr_burst_sequencer_lfsr
    import lfsr_burst_sequencer_pkg::*;
#(
    parameter int NUM_BITS = 5
) (
    input  logic                i_Clk,
    input  logic                i_Enable,
    input  logic                i_Seed_DV,
    input  logic [NUM_BITS-1:0] i_Seed_Data,
    output logic [NUM_BITS-1:0] o_LFSR_Data,
    output logic                o_LFSR_Done
);

    localparam logic [NUM_BITS-1:0] TAPS = NUM_BITS'(tap_mask(NUM_BITS));

    logic [NUM_BITS-1:0] lfsr;
    logic                feedback;

    // An XNOR over an even tap count equals the inverted XOR reduction.
    assign feedback = ~^(lfsr & TAPS);

    always_ff @(posedge i_Clk) begin
        if (i_Enable)
            lfsr <= i_Seed_DV ? i_Seed_Data : {lfsr[NUM_BITS-2:0], feedback};
    end

    assign o_LFSR_Data = lfsr;
    assign o_LFSR_Done = lfsr == i_Seed_Data;

endmodule

// File: rtl/lfsr_burst_sequencer.sv
// lfsr_burst_sequencer: accepts {seed, count} bursts and streams LFSR words under valid/ready.
module lfsr_burst_sequencer
    import lfsr_burst_sequencer_pkg::*;
#(
    parameter int NUM_BITS = 5,
    parameter int CNT_BITS = 16
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic                i_Cmd_Valid,
    output logic                o_Cmd_Ready,
    input  logic [NUM_BITS-1:0] i_Cmd_Seed,
    input  logic [CNT_BITS-1:0] i_Cmd_Count,
    input  logic                i_Abort,
    output logic [NUM_BITS-1:0] o_Data,
    output logic                o_Data_Valid,
    input  logic                i_Data_Ready,
    output logic                o_Busy,
    output logic                o_Done,
    output logic                o_Wrap
);

    localparam logic [CNT_BITS-1:0] FULL_PERIOD = CNT_BITS'({NUM_BITS{1'b1}});
    localparam logic [NUM_BITS-1:0] LOCKUP_SEED = '1;

    seq_state_t          state, state_d;
    logic [CNT_BITS-1:0] count;
    logic [NUM_BITS-1:0] seed;
    logic                first_word;
    logic                accept, transfer, lfsr_done;

    assign accept       = i_Cmd_Valid & o_Cmd_Ready;
    assign transfer     = o_Data_Valid & i_Data_Ready;
    assign o_Cmd_Ready  = (state == IDLE) & ~i_Rst;
    assign o_Data_Valid = state == RUN;
    assign o_Busy       = state != IDLE;
    assign o_Done       = state == DONE;
    assign o_Wrap       = transfer & lfsr_done & ~first_word;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = accept ? LOAD : IDLE;
            LOAD:    state_d = i_Abort ? IDLE : RUN;
            RUN:     state_d = i_Abort ? IDLE : (transfer && count == CNT_BITS'(1)) ? DONE : RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state      <= IDLE;
            count      <= '0;
            first_word <= 1'b0;
        end else begin
            state <= state_d;
            if (accept) begin
                count <= (i_Cmd_Count == '0) ? FULL_PERIOD : i_Cmd_Count;
                seed  <= (i_Cmd_Seed == LOCKUP_SEED) ? '0 : i_Cmd_Seed;
            end else if (transfer) begin
                count <= count - CNT_BITS'(1);
            end
            if (state == LOAD)
                first_word <= 1'b1;
            else if (transfer)
                first_word <= 1'b0;
        end
    end

    lfsr_burst_sequencer_lfsr #(
        .NUM_BITS(NUM_BITS)
    ) u_lfsr (
        .i_Clk       (i_Clk),
        .i_Enable    ((state == LOAD) | transfer),
        .i_Seed_DV   (state == LOAD),
        .i_Seed_Data (seed),
        .o_LFSR_Data (o_Data),
        .o_LFSR_Done (lfsr_done)
    );

endmodule

// File: tb/tb_lfsr_burst_sequencer.sv
// tb_lfsr_burst_sequencer: directed scenarios for the LFSR burst sequencer (NUM_BITS=5).
module tb_lfsr_burst_sequencer;

    logic       i_Clk = 1'b0;
    logic       i_Rst = 1'b1;
    logic       i_Cmd_Valid = 1'b0;
    logic       o_Cmd_Ready;
    logic [4:0] i_Cmd_Seed = '0;
    logic [15:0] i_Cmd_Count = '0;
    logic       i_Abort = 1'b0;
    logic [4:0] o_Data;
    logic       o_Data_Valid;
    logic       i_Data_Ready = 1'b1;
    logic       o_Busy, o_Done, o_Wrap;

    int tests = 0;
    int fails = 0;

    always #5 i_Clk = ~i_Clk;

    lfsr_burst_sequencer #(.NUM_BITS(5), .CNT_BITS(16)) dut (
        .i_Clk        (i_Clk),
        .i_Rst        (i_Rst),
        .i_Cmd_Valid  (i_Cmd_Valid),
        .o_Cmd_Ready  (o_Cmd_Ready),
        .i_Cmd_Seed   (i_Cmd_Seed),
        .i_Cmd_Count  (i_Cmd_Count),
        .i_Abort      (i_Abort),
        .o_Data       (o_Data),
        .o_Data_Valid (o_Data_Valid),
        .i_Data_Ready (i_Data_Ready),
        .o_Busy       (o_Busy),
        .o_Done       (o_Done),
        .o_Wrap       (o_Wrap)
    );

    task automatic step;
        @(posedge i_Clk);
        #1;
    endtask

    // Offers a command in the current cycle; returns one cycle later (LOAD), command withdrawn.
    task automatic issue(input logic [4:0] seed, input logic [15:0] cnt);
        i_Cmd_Valid = 1'b1;
        i_Cmd_Seed  = seed;
        i_Cmd_Count = cnt;
        #1;
        tests++;
        if (o_Cmd_Ready !== 1'b1) begin
            fails++;
            $display("FAIL issue_ready: got %b want 1", o_Cmd_Ready);
        end
        step;
        i_Cmd_Valid = 1'b0;
    endtask

    task automatic test_reset;
        i_Rst = 1'b1;
        step;
        step;
        tests++;
        if ({o_Cmd_Ready, o_Data_Valid, o_Busy, o_Done, o_Wrap} !== 5'b0) begin
            fails++;
            $display("FAIL reset_outputs: got rdy/vld/busy/done/wrap=%b want 00000",
                     {o_Cmd_Ready, o_Data_Valid, o_Busy, o_Done, o_Wrap});
        end
        i_Rst = 1'b0;
        #1;
        tests++;
        if (o_Cmd_Ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got %b want 1", o_Cmd_Ready);
        end
    endtask

    task automatic test_basic;
        logic [4:0] exp [4] = '{5'h01, 5'h03, 5'h07, 5'h0E};
        i_Data_Ready = 1'b1;
        issue(5'h01, 16'd4);
        #1;
        tests++;
        if (o_Data_Valid !== 1'b0 || o_Busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_load: got vld=%b busy=%b want 0 1", o_Data_Valid, o_Busy);
        end
        for (int i = 0; i < 4; i++) begin
            step;
            tests++;
            if (o_Data_Valid !== 1'b1 || o_Data !== exp[i] || o_Wrap !== 1'b0) begin
                fails++;
                $display("FAIL basic_word%0d: got vld=%b data=%h wrap=%b want 1 %h 0",
                         i, o_Data_Valid, o_Data, o_Wrap, exp[i]);
            end
        end
        step;
        tests++;
        if (o_Done !== 1'b1 || o_Data_Valid !== 1'b0 || o_Cmd_Ready !== 1'b0) begin
            fails++;
            $display("FAIL basic_done: got done=%b vld=%b rdy=%b want 1 0 0",
                     o_Done, o_Data_Valid, o_Cmd_Ready);
        end
        step;
        tests++;
        if (o_Done !== 1'b0 || o_Cmd_Ready !== 1'b1) begin
            fails++;
            $display("FAIL basic_idle: got done=%b rdy=%b want 0 1", o_Done, o_Cmd_Ready);
        end
    endtask

    task automatic test_full_period;
        logic [31:0] seen = '0;
        int words = 0, dups = 0, wraps = 0, dones = 0;
        issue(5'h01, 16'd0);
        for (int k = 0; k < 45; k++) begin
            step;
            if (o_Data_Valid) begin
                words++;
                if (seen[o_Data]) dups++;
                seen[o_Data] = 1'b1;
            end
            if (o_Wrap) wraps++;
            if (o_Done) dones++;
        end
        tests++;
        if (words != 31 || dups != 0 || wraps != 0 || dones != 1 || seen[31] !== 1'b0) begin
            fails++;
            $display("FAIL full_period: got words=%0d dups=%0d wraps=%0d dones=%0d seen1F=%b want 31 0 0 1 0",
                     words, dups, wraps, dones, seen[31]);
        end
    endtask

    task automatic test_wrap;
        int words = 0, wraps = 0, dones = 0;
        logic [4:0] data32 = '0;
        logic wrap32 = 1'b0;
        issue(5'h01, 16'd32);
        for (int k = 0; k < 45; k++) begin
            step;
            if (o_Data_Valid) begin
                words++;
                if (words == 32) begin
                    data32 = o_Data;
                    wrap32 = o_Wrap;
                end
            end
            if (o_Wrap) wraps++;
            if (o_Done) dones++;
        end
        tests++;
        if (words != 32 || data32 !== 5'h01 || wrap32 !== 1'b1 || wraps != 1 || dones != 1) begin
            fails++;
            $display("FAIL wrap: got words=%0d w32=%h wrap32=%b wraps=%0d dones=%0d want 32 01 1 1 1",
                     words, data32, wrap32, wraps, dones);
        end
    endtask

    task automatic test_backpressure;
        i_Data_Ready = 1'b1;
        issue(5'h01, 16'd4);
        step;
        step;
        i_Data_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (o_Data_Valid !== 1'b1 || o_Data !== 5'h03 || o_Wrap !== 1'b0) begin
                fails++;
                $display("FAIL stall%0d: got vld=%b data=%h wrap=%b want 1 03 0",
                         i, o_Data_Valid, o_Data, o_Wrap);
            end
            step;
        end
        i_Data_Ready = 1'b1;
        step;
        tests++;
        if (o_Data !== 5'h07 || o_Data_Valid !== 1'b1) begin
            fails++;
            $display("FAIL resume_07: got vld=%b data=%h want 1 07", o_Data_Valid, o_Data);
        end
        step;
        tests++;
        if (o_Data !== 5'h0E) begin
            fails++;
            $display("FAIL resume_0E: got %h want 0E", o_Data);
        end
        step;
        tests++;
        if (o_Done !== 1'b1) begin
            fails++;
            $display("FAIL stall_done: got %b want 1", o_Done);
        end
        step;
    endtask

    task automatic test_lockup_seed;
        issue(5'h1F, 16'd2);
        step;
        tests++;
        if (o_Data !== 5'h00 || o_Data_Valid !== 1'b1) begin
            fails++;
            $display("FAIL lockup_first: got vld=%b data=%h want 1 00", o_Data_Valid, o_Data);
        end
        step;
        tests++;
        if (o_Data !== 5'h01) begin
            fails++;
            $display("FAIL lockup_second: got %h want 01", o_Data);
        end
        step;
        step;
    endtask

    task automatic test_abort(input bit use_reset);
        issue(5'h01, 16'd10);
        step;
        step;
        if (use_reset) i_Rst = 1'b1;
        else           i_Abort = 1'b1;
        #1;
        tests++;
        if (o_Data !== 5'h03 || o_Cmd_Ready !== 1'b0) begin
            fails++;
            $display("FAIL kill_word2: got data=%h rdy=%b want 03 0", o_Data, o_Cmd_Ready);
        end
        step;
        i_Rst   = 1'b0;
        i_Abort = 1'b0;
        #1;
        tests++;
        if (o_Data_Valid !== 1'b0 || o_Done !== 1'b0 || o_Busy !== 1'b0 || o_Cmd_Ready !== 1'b1) begin
            fails++;
            $display("FAIL kill_idle(rst=%0d): got vld=%b done=%b busy=%b rdy=%b want 0 0 0 1",
                     use_reset, o_Data_Valid, o_Done, o_Busy, o_Cmd_Ready);
        end
        issue(5'h01, 16'd2);
        step;
        tests++;
        if (o_Data !== 5'h01 || o_Data_Valid !== 1'b1) begin
            fails++;
            $display("FAIL kill_restart1: got vld=%b data=%h want 1 01", o_Data_Valid, o_Data);
        end
        step;
        tests++;
        if (o_Data !== 5'h03) begin
            fails++;
            $display("FAIL kill_restart2: got %h want 03", o_Data);
        end
        step;
        tests++;
        if (o_Done !== 1'b1) begin
            fails++;
            $display("FAIL kill_restart_done: got %b want 1", o_Done);
        end
        step;
    endtask

    task automatic test_back_to_back;
        logic       exp_v [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       exp_r [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [4:0] exp_d [8] = '{5'h00, 5'h00, 5'h01, 5'h03, 5'h00, 5'h00, 5'h00, 5'h05};
        i_Data_Ready = 1'b1;
        i_Cmd_Valid  = 1'b1;
        i_Cmd_Seed   = 5'h01;
        i_Cmd_Count  = 16'd2;
        for (int c = 0; c < 8; c++) begin
            if (c == 1) begin
                i_Cmd_Seed  = 5'h05;
                i_Cmd_Count = 16'd1;
            end
            if (c == 6) i_Cmd_Valid = 1'b0;
            #1;
            tests++;
            if (o_Data_Valid !== exp_v[c] || o_Cmd_Ready !== exp_r[c] ||
                (exp_v[c] && o_Data !== exp_d[c])) begin
                fails++;
                $display("FAIL b2b_cycle%0d: got vld=%b rdy=%b data=%h want %b %b %h",
                         c, o_Data_Valid, o_Cmd_Ready, o_Data, exp_v[c], exp_r[c], exp_d[c]);
            end
            step;
        end
        tests++;
        if (o_Done !== 1'b1) begin
            fails++;
            $display("FAIL b2b_done: got %b want 1", o_Done);
        end
        step;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_full_period;
        test_wrap;
        test_backpressure;
        test_lockup_seed;
        test_abort(1'b0);
        test_abort(1'b1);
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
